// File: rtl/check_node_minfind_pkg.sv
// check_node_minfind_pkg: shared widths, offset default and FSM encoding for the check-node min-finder.
package check_node_minfind_pkg;
   localparam int INI_BW = 6;
   localparam int EX_BW = 2;
   localparam int OFFSET_DEF = 1;
   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;
endpackage

// File: rtl/check_node_minfind_cmp2.sv
// check_node_minfind_cmp2: one-beat min1/min2/index update; ties with min1 fall to min2 so the earliest index is kept.
module check_node_minfind_cmp2 #(
   parameter int MAG_W = 8,
   parameter int IDX_W = 5
) (
   input  logic [MAG_W-1:0] mag,
   input  logic [MAG_W-1:0] min1,
   input  logic [MAG_W-1:0] min2,
   input  logic [IDX_W-1:0] idx,
   input  logic [IDX_W-1:0] pos,
   output logic [MAG_W-1:0] min1_n,
   output logic [MAG_W-1:0] min2_n,
   output logic [IDX_W-1:0] idx_n
);
   always_comb begin
      min1_n = (mag < min1) ? mag : min1;
      min2_n = (mag < min1) ? min1 : (mag < min2) ? mag : min2;
      idx_n = (mag < min1) ? pos : idx;
   end
endmodule

// File: rtl/check_node_minfind.sv
// check_node_minfind: streaming offset-min-sum check-node row reducer (two minima, argmin, signs, degree).
module check_node_minfind
   import check_node_minfind_pkg::*;
#(
   parameter int MAG_W = INI_BW + EX_BW,
   parameter int DEG_MAX = 32,
   parameter int IDX_W = 5,
   parameter int OFFSET = OFFSET_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic               in_first,
   input  logic               in_last,
   input  logic               sign_in,
   input  logic [MAG_W-1:0]   mag_in,
   output logic               out_valid,
   output logic [MAG_W-1:0]   min1_out,
   output logic [MAG_W-1:0]   min2_out,
   output logic [IDX_W-1:0]   min1_idx,
   output logic               sign_prod,
   output logic [DEG_MAX-1:0] sign_vec,
   output logic [IDX_W:0]     deg_out,
   output logic               ovf_err
);
   localparam logic [IDX_W:0] DEG_L = (IDX_W+1)'(DEG_MAX);
   state_t state, nxt_state;
   logic [MAG_W-1:0] min1, min2, nxt_min1, nxt_min2, c_min1, c_min2;
   logic [IDX_W-1:0] idx, nxt_idx, c_idx;
   logic [IDX_W:0] count, nxt_count;
   logic [DEG_MAX-1:0] vec, nxt_vec;
   logic sign_acc, nxt_sign, ovf, nxt_ovf, start, more, accept;

   function automatic logic [MAG_W-1:0] sub_off(input logic [MAG_W-1:0] m);
      logic [MAG_W:0] e;
      e = {1'b0, m};
      return (e > (MAG_W+1)'(OFFSET)) ? MAG_W'(e - (MAG_W+1)'(OFFSET)) : '0;
   endfunction

   // in_first restarts a row from any state, including DONE for back-to-back rows
   assign start = in_valid & in_first;
   assign more = in_valid & ~in_first & (state == S_ACCUM);
   assign accept = more & (count < DEG_L);

   check_node_minfind_cmp2 #(.MAG_W(MAG_W), .IDX_W(IDX_W)) u_cmp (
      .mag(mag_in),
      .min1(min1),
      .min2(min2),
      .idx(idx),
      .pos(count[IDX_W-1:0]),
      .min1_n(c_min1),
      .min2_n(c_min2),
      .idx_n(c_idx)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else state <= nxt_state;

   always_comb
      nxt_state = start ? (in_last ? S_DONE : S_ACCUM) :
                  (state == S_ACCUM) ? ((in_valid & in_last) ? S_DONE : S_ACCUM) : S_IDLE;

   always_comb out_valid = (state == S_DONE);

   // beats past DEG_MAX are dropped from the accumulators but flag overflow
   always_comb begin
      nxt_min1 = start ? mag_in : accept ? c_min1 : min1;
      nxt_min2 = start ? '1 : accept ? c_min2 : min2;
      nxt_idx = start ? '0 : accept ? c_idx : idx;
      nxt_sign = start ? sign_in : sign_acc ^ (accept & sign_in);
      nxt_vec = start ? DEG_MAX'(sign_in) : vec | (DEG_MAX'(accept & sign_in) << count);
      nxt_count = start ? (IDX_W+1)'(1) : count + (IDX_W+1)'(accept);
      nxt_ovf = ~start & (ovf | (more & ~accept));
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         min1 <= '0;
         min2 <= '0;
         idx <= '0;
         sign_acc <= 1'b0;
         vec <= '0;
         count <= '0;
         ovf <= 1'b0;
      end else begin
         min1 <= nxt_min1;
         min2 <= nxt_min2;
         idx <= nxt_idx;
         sign_acc <= nxt_sign;
         vec <= nxt_vec;
         count <= nxt_count;
         ovf <= nxt_ovf;
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         min1_out <= '0;
         min2_out <= '0;
         min1_idx <= '0;
         sign_prod <= 1'b0;
         sign_vec <= '0;
         deg_out <= '0;
         ovf_err <= 1'b0;
      end else if (nxt_state == S_DONE) begin
         min1_out <= sub_off(nxt_min1);
         min2_out <= sub_off(nxt_min2);
         min1_idx <= nxt_idx;
         sign_prod <= nxt_sign;
         sign_vec <= nxt_vec;
         deg_out <= nxt_count;
         ovf_err <= nxt_ovf;
      end
endmodule

// File: tb/tb_check_node_minfind.sv
// tb_check_node_minfind: randomized rows against a sort-style reference model, plus fixed corner rows.
module tb_check_node_minfind;
   localparam int DEG = 32;
   localparam int OFF = 1;

   typedef struct packed {
      logic [7:0]  m1;
      logic [7:0]  m2;
      logic [4:0]  idx;
      logic        sp;
      logic [31:0] sv;
      logic [5:0]  deg;
      logic        ovf;
   } res_t;

   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, sign_in = 1'b0;
   logic [7:0] mag_in = '0;
   logic out_valid, sign_prod, ovf_err;
   logic [7:0] min1_out, min2_out;
   logic [4:0] min1_idx;
   logic [31:0] sign_vec;
   logic [5:0] deg_out;
   res_t got, exp_r, exp_b;
   int n_cmp = 0, n_err = 0, pulses = 0, p0;
   int rm[$];
   bit rs[$];

   check_node_minfind dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
      .in_last(in_last), .sign_in(sign_in), .mag_in(mag_in), .out_valid(out_valid),
      .min1_out(min1_out), .min2_out(min2_out), .min1_idx(min1_idx),
      .sign_prod(sign_prod), .sign_vec(sign_vec), .deg_out(deg_out), .ovf_err(ovf_err)
   );

   assign got = {min1_out, min2_out, min1_idx, sign_prod, sign_vec, deg_out, ovf_err};

   always #5 clk = ~clk;
   always @(posedge clk) if (out_valid === 1'b1) pulses++;

   function automatic int off(input int x);
      return (x > OFF) ? x - OFF : 0;
   endfunction

   // smallest = first occurrence of the minimum; second = minimum of everything else
   function automatic res_t model(input int m[$], input bit s[$]);
      res_t r;
      int n, b, m2;
      r = '0;
      n = (m.size() > DEG) ? DEG : m.size();
      b = 0;
      m2 = 255;
      for (int i = 1; i < n; i++) if (m[i] < m[b]) b = i;
      for (int i = 0; i < n; i++) if (i != b && m[i] < m2) m2 = m[i];
      for (int i = 0; i < n; i++) begin
         r.sp ^= s[i];
         r.sv[i] = s[i];
      end
      r.m1 = 8'(off(m[b]));
      r.m2 = 8'(off(m2));
      r.idx = 5'(b);
      r.deg = 6'(n);
      r.ovf = m.size() > DEG;
      return r;
   endfunction

   task automatic rand_row(input int n, input int maxm);
      rm.delete();
      rs.delete();
      for (int i = 0; i < n; i++) begin
         rm.push_back($urandom_range(maxm, 0));
         rs.push_back(1'($urandom_range(1, 0)));
      end
   endtask

   // called at a negedge; returns at the negedge after the last beat's sampling edge
   task automatic drive_row();
      for (int i = 0; i < rm.size(); i++) begin
         in_valid = 1'b1;
         in_first = (i == 0);
         in_last = (i == rm.size() - 1);
         sign_in = rs[i];
         mag_in = 8'(rm[i]);
         @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      #3;
      n_cmp++;
      if ({out_valid, got} !== '0) begin
         n_err++;
         $display("FAIL reset_state: got %h want 0", {out_valid, got});
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_known_row();
      rm = '{5, 3, 7, 3, 9};
      rs = '{0, 1, 1, 0, 0};
      exp_r = '{8'd2, 8'd2, 5'd1, 1'b0, 32'b00110, 6'd5, 1'b0};
      drive_row();
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL known_valid: got %b want 1", out_valid);
      end
      n_cmp++;
      if (got !== exp_r) begin
         n_err++;
         $display("FAIL known_row: got %h want %h", got, exp_r);
      end
      idle(1);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL known_pulse_end: got %b want 0", out_valid);
      end
      n_cmp++;
      if (got !== exp_r) begin
         n_err++;
         $display("FAIL known_hold: got %h want %h", got, exp_r);
      end
   endtask

   task automatic test_degree1();
      rm = '{4};
      rs = '{1};
      exp_r = '{8'd3, 8'd254, 5'd0, 1'b1, 32'd1, 6'd1, 1'b0};
      drive_row();
      n_cmp++;
      if (out_valid !== 1'b1 || got !== exp_r) begin
         n_err++;
         $display("FAIL degree1: got v=%b %h want v=1 %h", out_valid, got, exp_r);
      end
      idle(1);
   endtask

   task automatic test_floor();
      rm = '{7, 1, 0, 5};
      rs = '{1, 1, 0, 1};
      exp_r = '{8'd0, 8'd0, 5'd2, 1'b1, 32'b1011, 6'd4, 1'b0};
      drive_row();
      n_cmp++;
      if (out_valid !== 1'b1 || got !== exp_r) begin
         n_err++;
         $display("FAIL floor: got v=%b %h want v=1 %h", out_valid, got, exp_r);
      end
      idle(1);
   endtask

   task automatic test_random();
      for (int k = 0; k < 25; k++) begin
         rand_row($urandom_range(DEG, 1), (k % 3 == 0) ? 3 : 255);
         exp_r = model(rm, rs);
         drive_row();
         n_cmp++;
         if (out_valid !== 1'b1 || got !== exp_r) begin
            n_err++;
            $display("FAIL random_row%0d: got v=%b %h want v=1 %h", k, out_valid, got, exp_r);
         end
         idle($urandom_range(2, 0));
      end
      idle(1);
   endtask

   task automatic test_back_to_back();
      p0 = pulses;
      rand_row($urandom_range(8, 2), 255);
      exp_r = model(rm, rs);
      drive_row();
      n_cmp++;
      if (out_valid !== 1'b1 || got !== exp_r) begin
         n_err++;
         $display("FAIL b2b_first: got v=%b %h want v=1 %h", out_valid, got, exp_r);
      end
      rand_row($urandom_range(8, 1), 255);
      exp_b = model(rm, rs);
      drive_row();
      n_cmp++;
      if (out_valid !== 1'b1 || got !== exp_b) begin
         n_err++;
         $display("FAIL b2b_second: got v=%b %h want v=1 %h", out_valid, got, exp_b);
      end
      idle(2);
      n_cmp++;
      if (pulses !== p0 + 2) begin
         n_err++;
         $display("FAIL b2b_pulses: got %0d want %0d", pulses - p0, 2);
      end
   endtask

   task automatic test_overflow();
      rand_row(DEG, 255);
      for (int i = 0; i < DEG; i++) if (rm[i] < 10) rm[i] = 10;
      for (int i = 0; i < 3; i++) begin
         rm.push_back(0);
         rs.push_back(1'b1);
      end
      exp_r = model(rm, rs);
      drive_row();
      n_cmp++;
      if (deg_out !== 6'd32 || ovf_err !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_flags: got deg=%0d ovf=%b want deg=32 ovf=1", deg_out, ovf_err);
      end
      n_cmp++;
      if (out_valid !== 1'b1 || got !== exp_r) begin
         n_err++;
         $display("FAIL ovf_row: got v=%b %h want v=1 %h", out_valid, got, exp_r);
      end
      idle(1);
      rand_row(3, 255);
      exp_r = model(rm, rs);
      drive_row();
      n_cmp++;
      if (got !== exp_r) begin
         n_err++;
         $display("FAIL ovf_cleared: got %h want %h", got, exp_r);
      end
      idle(1);
   endtask

   task automatic test_restart();
      p0 = pulses;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_first = (i == 0);
         in_last = 1'b0;
         sign_in = 1'b1;
         mag_in = 8'd0;
         @(negedge clk);
      end
      rand_row(5, 255);
      for (int i = 0; i < 5; i++) if (rm[i] == 0) rm[i] = 1;
      exp_r = model(rm, rs);
      drive_row();
      n_cmp++;
      if (out_valid !== 1'b1 || got !== exp_r) begin
         n_err++;
         $display("FAIL restart_row: got v=%b %h want v=1 %h", out_valid, got, exp_r);
      end
      idle(1);
      n_cmp++;
      if (pulses !== p0 + 1) begin
         n_err++;
         $display("FAIL restart_pulses: got %0d want 1", pulses - p0);
      end
   endtask

   task automatic test_idle_discard();
      p0 = pulses;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_first = 1'b0;
         in_last = 1'b1;
         sign_in = 1'b1;
         mag_in = 8'd0;
         @(negedge clk);
      end
      idle(2);
      n_cmp++;
      if (pulses !== p0) begin
         n_err++;
         $display("FAIL discard_pulses: got %0d want 0", pulses - p0);
      end
      rand_row(6, 255);
      exp_r = model(rm, rs);
      drive_row();
      n_cmp++;
      if (out_valid !== 1'b1 || got !== exp_r) begin
         n_err++;
         $display("FAIL discard_row: got v=%b %h want v=1 %h", out_valid, got, exp_r);
      end
      idle(1);
   endtask

   task automatic test_reset_mid_row();
      rand_row(4, 255);
      rm[0] = 200;
      rs[0] = 1'b1;
      drive_row();
      idle(1);
      rand_row(6, 255);
      rm.pop_back();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_first = (i == 0);
         in_last = 1'b0;
         sign_in = rs[i];
         mag_in = 8'(rm[i]);
         @(negedge clk);
      end
      p0 = pulses;
      #2;
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      n_cmp++;
      if ({out_valid, got} !== '0) begin
         n_err++;
         $display("FAIL midrow_reset: got %h want 0", {out_valid, got});
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);
      n_cmp++;
      if (pulses !== p0) begin
         n_err++;
         $display("FAIL midrow_pulses: got %0d want 0", pulses - p0);
      end
      rand_row(7, 255);
      exp_r = model(rm, rs);
      drive_row();
      n_cmp++;
      if (out_valid !== 1'b1 || got !== exp_r) begin
         n_err++;
         $display("FAIL midrow_after: got v=%b %h want v=1 %h", out_valid, got, exp_r);
      end
      idle(1);
   endtask

   initial begin
      test_reset();
      test_known_row();
      test_degree1();
      test_floor();
      test_random();
      test_back_to_back();
      test_overflow();
      test_restart();
      test_idle_discard();
      test_reset_mid_row();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
